// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid stage and its data registers.
// Holds the occupancy state encoding and the default bundle widths used by the
// X->M and M->W stage instances.
package pipe_pkg;

  // Occupancy of the stage: EMPTY holds nothing, ONE holds a beat in the main
  // register, FULL holds a beat in main plus a second beat in the skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  // Default payload width shared by the XM and MW bundles
  // (ALU result + immediate + rf mux select).
  localparam int PIPE_DATA_W = 66;

  // Default width of the stall performance counter.
  localparam int PIPE_CNT_W = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and asynchronous active-low reset.
// Used twice by pipe_skid_stage: once as the main (head) register and once as
// the skid register holding the second beat.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Capture the payload only when the owning stage accepts a beat into this slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// The main register drives the outputs; the skid register absorbs the one beat
// that can arrive while the stage is being backpressured, so in_ready never
// depends combinationally on out_ready and throughput stays at one beat/cycle.
// Optional feature: define PIPE_SKID_PERF_EN to build a saturating stall counter;
// without it stall_cnt is tied to zero.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state;
  logic              run;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  // run stays low for the first edge after reset release so that edge can
  // never be taken as an input transfer, whatever in_valid is doing.
  assign in_ready = rst & run & (state != FULL);
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // Decide which data slot loads this cycle and from where; flush suppresses
  // every load because the incoming beat is being discarded.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    if (!flush) begin
      case (state)
        EMPTY: main_load = xfer_in;
        ONE: begin
          main_load = xfer_in & xfer_out;
          skid_load = xfer_in & ~xfer_out;
        end
        FULL: begin
          main_load = xfer_out;
          main_d    = skid_q;
        end
        default: begin
          main_load = 1'b0;
          skid_load = 1'b0;
        end
      endcase
    end
  end

  // Occupancy state machine with registered out_valid; flush wins over any
  // same-cycle transfer and empties the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (xfer_in) begin
              state     <= ONE;
              out_valid <= 1'b1;
            end
          end
          ONE: begin
            if (xfer_in && !xfer_out) begin
              state <= FULL;
            end else if (!xfer_in && xfer_out) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          FULL: begin
            if (xfer_out) begin
              state <= ONE;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  pipe_data_reg #(.DATA_W(DATA_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_q;

  // Count cycles where a valid beat is held back by downstream; saturates at
  // all-ones and survives flush, only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a table of one-cycle vectors with
// expected post-edge outputs, plus hand-written sequences for reset, async
// reset mid-transfer and the stall counter (PIPE_SKID_PERF_EN aware).
module tb_pipe_skid_stage;

  localparam int DW = 66;
  localparam int CW = 4;

`ifdef PIPE_SKID_PERF_EN
  localparam logic [CW-1:0] EXP_CNT5   = 4'd5;
  localparam logic [CW-1:0] EXP_CNTSAT = 4'd15;
`else
  localparam logic [CW-1:0] EXP_CNT5   = 4'd0;
  localparam logic [CW-1:0] EXP_CNTSAT = 4'd0;
`endif

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic          exp_ir;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] stall_cnt;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic iv, input logic [DW-1:0] id, input logic ordy,
                         input logic fl, input logic exp_ov, input logic [DW-1:0] exp_od,
                         input logic exp_ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.exp_ov = exp_ov; v.exp_od = exp_od; v.exp_ir = exp_ir;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] id,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // T2 streaming 0x1..0x8 with out_ready=1
    for (int k = 1; k <= 8; k++) add_vec(1, DW'(k), 1, 0, 1, DW'(k), 1);
    add_vec(0, 66'h0, 1, 0, 0, 66'h8, 1);
    // T3 backpressure: A accepted, B into skid, C refused while FULL
    add_vec(1, 66'hA, 0, 0, 1, 66'hA, 1);
    add_vec(1, 66'hB, 0, 0, 1, 66'hA, 0);
    add_vec(1, 66'hC, 0, 0, 1, 66'hA, 0);
    add_vec(1, 66'hC, 1, 0, 1, 66'hB, 1);
    add_vec(1, 66'hC, 1, 0, 1, 66'hC, 1);
    add_vec(0, 66'h0, 1, 0, 0, 66'hC, 1);
    // T4 flush from FULL with an incoming beat 0xD that must vanish
    add_vec(1, 66'hA, 0, 0, 1, 66'hA, 1);
    add_vec(1, 66'hB, 0, 0, 1, 66'hA, 0);
    add_vec(1, 66'hD, 0, 1, 0, 66'hA, 1);
    add_vec(0, 66'h0, 1, 0, 0, 66'hA, 1);
    add_vec(1, 66'hE, 1, 0, 1, 66'hE, 1);
    // ONE holds when neither side moves, then drains
    add_vec(0, 66'h0, 0, 0, 1, 66'hE, 1);
    add_vec(0, 66'h0, 1, 0, 0, 66'hE, 1);
    // Flush from ONE with both sides active; wide payload through the stage
    add_vec(1, 66'h3_0123_4567_89AB_CDEF, 1, 0, 1, 66'h3_0123_4567_89AB_CDEF, 1);
    add_vec(1, 66'h6, 1, 1, 0, 66'h3_0123_4567_89AB_CDEF, 1);
    add_vec(0, 66'h0, 1, 0, 0, 66'h3_0123_4567_89AB_CDEF, 1);

    // T1 reset held with in_valid=1
    rst = 1'b0;
    applyStimulus(1, 66'h55, 1, 0);
    tick();
    tick();
    checkOutput("reset out_valid", DW'(out_valid), 66'h0);
    checkOutput("reset in_ready", DW'(in_ready), 66'h0);
    checkOutput("reset stall_cnt", DW'(stall_cnt), 66'h0);
    checkOutput("reset out_data", out_data, 66'h0);
    @(negedge clk);
    applyStimulus(0, 66'h0, 1, 0);
    rst = 1'b1;
    tick();
    checkOutput("release in_ready", DW'(in_ready), 66'h1);
    checkOutput("release out_valid", DW'(out_valid), 66'h0);

    // Table-driven vectors: apply for one cycle, compare after the edge
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].exp_ov));
      checkOutput($sformatf("vec%0d in_ready", i), DW'(in_ready), DW'(vecs[i].exp_ir));
      checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_od);
    end

    // Async reset mid-transfer: out_valid drops without waiting for an edge
    applyStimulus(1, 66'h77, 0, 0);
    tick();
    checkOutput("pre-reset out_valid", DW'(out_valid), 66'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async out_valid", DW'(out_valid), 66'h0);
    checkOutput("async in_ready", DW'(in_ready), 66'h0);
    checkOutput("async out_data", out_data, 66'h0);
    @(negedge clk);
    applyStimulus(0, 66'h0, 0, 0);
    rst = 1'b1;
    tick();
    checkOutput("rerelease in_ready", DW'(in_ready), 66'h1);
    checkOutput("rerelease stall_cnt", DW'(stall_cnt), 66'h0);

    // T5 stall counter: one beat held with out_ready=0
    applyStimulus(1, 66'h99, 0, 0);
    tick();
    applyStimulus(0, 66'h0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("stall_cnt after 5", DW'(stall_cnt), DW'(EXP_CNT5));
    for (int k = 0; k < 15; k++) tick();
    checkOutput("stall_cnt saturated", DW'(stall_cnt), DW'(EXP_CNTSAT));
    checkOutput("stall held data", out_data, 66'h99);
    applyStimulus(0, 66'h0, 0, 1);
    tick();
    applyStimulus(0, 66'h0, 1, 0);
    tick();
    checkOutput("post-flush out_valid", DW'(out_valid), 66'h0);
    checkOutput("post-flush stall_cnt", DW'(stall_cnt), DW'(EXP_CNTSAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
